reg_file_sb: RTL and testbench

- Parametrised successor to the CPU's 8x16 register file.
- Configurable data width and register count, with a separate write address, an optional hardwired zero register, and optional write-to-read bypass.
- Adds a per-register pending scoreboard so the decode stage can detect operands whose multi-cycle producer (e.g. a load) has not yet written back.
- Sits between decode (read ports, SetPend) and writeback (write port).

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 45 ++++
 rtl/reg_file_sb.sv | 80 ++++++++
 tb/tb_reg_file_sb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // A write only lands when enabled and not aimed at the hardwired zero register.
  function automatic logic write_qual(input logic we, input logic zero_reg_en,
                                      input logic addr_is_zero);
    return we && !(zero_reg_en && addr_is_zero);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set by decode when a multi-cycle producer issues,
// cleared by writeback. Two lookup ports plus an any-pending summary.
module reg_scoreboard #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] look_a,
  input  logic [AW-1:0] look_b,
  output logic          pend_a,
  output logic          pend_b,
  output logic          pend_any
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             set_ok;

  // Register 0 never becomes pending when it is hardwired to zero.
  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // Clear first, then set, so a new producer issued as the old one retires wins.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_addr] = 1'b0;
    if (set_ok) pend_nxt[set_addr] = 1'b1;
  end

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign pend_a   = pend[look_a];
  assign pend_b   = pend[look_b];
  assign pend_any = |pend;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with optional zero register, optional
// write-to-read bypass and a pending scoreboard for decode hazard checks.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RegWrite,
  input  logic [AW-1:0]    writeReg,
  input  logic [WIDTH-1:0] writeValue,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  output logic [WIDTH-1:0] ReadA,
  output logic [WIDTH-1:0] ReadB,
  output logic             ValidA,
  output logic             ValidB,
  input  logic             SetPend,
  input  logic [AW-1:0]    pendReg,
  output logic             PendAny
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic wr_ok;
  logic byp_ok;
  logic hit_a, hit_b;
  logic zero_a, zero_b;
  logic pend_a, pend_b;

  assign wr_ok  = write_qual(RegWrite, ZERO_REG != 0, writeReg == '0);
  // Nothing may be forwarded while reset holds the outputs at their reset values.
  assign byp_ok = (BYPASS != 0) && RST_N && wr_ok;
  assign hit_a  = byp_ok && (writeReg == srcA);
  assign hit_b  = byp_ok && (writeReg == srcB);
  assign zero_a = (ZERO_REG != 0) && (srcA == '0);
  assign zero_b = (ZERO_REG != 0) && (srcB == '0);

  // Storage array; the last write to a register wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     regs <= '0;
    else if (wr_ok) regs[writeReg] <= writeValue;
  end

  // Read muxing: zero register overrides bypass, bypass overrides storage.
  always_comb begin
    ReadA = regs[srcA];
    ReadB = regs[srcB];
    if (hit_a)  ReadA = writeValue;
    if (hit_b)  ReadB = writeValue;
    if (zero_a) ReadA = '0;
    if (zero_b) ReadB = '0;
  end

  reg_scoreboard #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr_en  (RegWrite),
    .clr_addr(writeReg),
    .set_en  (SetPend),
    .set_addr(pendReg),
    .look_a  (srcA),
    .look_b  (srcB),
    .pend_a  (pend_a),
    .pend_b  (pend_b),
    .pend_any(PendAny)
  );

  assign ValidA = !pend_a || hit_a || zero_a;
  assign ValidB = !pend_b || hit_b || zero_b;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb against an array/bitmap reference model.
module tb_reg_file_sb;

  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         RegWrite;
  logic [A-1:0] writeReg;
  logic [W-1:0] writeValue;
  logic [A-1:0] srcA, srcB;
  logic [W-1:0] ReadA, ReadB;
  logic         ValidA, ValidB;
  logic         SetPend;
  logic [A-1:0] pendReg;
  logic         PendAny;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents and pending flags.
  logic [W-1:0] mem [D];
  bit           pnd [D];

  reg_file_sb dut (
    .CLK(CLK), .RST_N(RST_N), .RegWrite(RegWrite), .writeReg(writeReg),
    .writeValue(writeValue), .srcA(srcA), .srcB(srcB), .ReadA(ReadA),
    .ReadB(ReadB), .ValidA(ValidA), .ValidB(ValidB), .SetPend(SetPend),
    .pendReg(pendReg), .PendAny(PendAny)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] exp_read(input logic [A-1:0] a);
    if (a == 0) return '0;
    if (RegWrite && writeReg == a) return writeValue;
    return mem[a];
  endfunction

  function automatic logic exp_valid(input logic [A-1:0] a);
    if (a == 0) return 1'b1;
    if (RegWrite && writeReg == a) return 1'b1;
    return !pnd[a];
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < D; i++) if (pnd[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < D; i++) begin
      mem[i] = '0;
      pnd[i] = 1'b0;
    end
  endfunction

  // Take a rising edge with the current inputs and advance the model.
  task automatic commit();
    @(posedge CLK);
    if (RST_N) begin
      if (RegWrite && writeReg != 0) mem[writeReg] = writeValue;
      if (RegWrite) pnd[writeReg] = 1'b0;
      if (SetPend && pendReg != 0) pnd[pendReg] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; SetPend = 0; writeReg = 0; pendReg = 0; writeValue = 0;
  endtask

  task automatic test_reset();
    RST_N = 0; idle(); srcA = 0; srcB = 0;
    model_clear();
    #1;
    // Writes and SetPend during reset must not show or stick.
    RegWrite = 1; writeReg = 3; writeValue = 16'h5A5A; srcA = 3;
    SetPend = 1; pendReg = 3;
    #1; checks++;
    if (ReadA !== 16'h0) begin errors++; $display("FAIL reset_bypass ReadA got %h want 0000", ReadA); end
    checks++;
    if (ValidA !== 1'b1) begin errors++; $display("FAIL reset_bypass ValidA got %b want 1", ValidA); end
    commit();
    idle();
    @(negedge CLK); RST_N = 1; #1;
    for (int i = 0; i < D; i++) begin
      srcA = A'(i); srcB = A'(D - 1 - i); #1;
      checks++;
      if (ReadA !== 16'h0 || ReadB !== 16'h0) begin
        errors++; $display("FAIL reset_read addr %0d got A=%h B=%h want 0000", i, ReadA, ReadB);
      end
      checks++;
      if (ValidA !== 1'b1 || ValidB !== 1'b1 || PendAny !== 1'b0) begin
        errors++; $display("FAIL reset_valid addr %0d got VA=%b VB=%b PA=%b want 1 1 0", i, ValidA, ValidB, PendAny);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 1; i < D; i++) begin
      RegWrite = 1; writeReg = A'(i); writeValue = W'(i);
      commit();
    end
    idle(); srcA = 6; srcB = 7; #1;
    checks++;
    if (ReadA !== 16'h0006 || ReadB !== 16'h0007) begin
      errors++; $display("FAIL write_read got A=%h B=%h want 0006 0007", ReadA, ReadB);
    end
    srcA = 5; srcB = 5; #1;
    checks++;
    if (ReadA !== 16'h0005 || ReadB !== 16'h0005) begin
      errors++; $display("FAIL same_src got A=%h B=%h want 0005 0005", ReadA, ReadB);
    end
  endtask

  task automatic test_zero_reg();
    RegWrite = 1; writeReg = 0; writeValue = 16'hABCD; srcA = 0; #1;
    checks++;
    if (ReadA !== 16'h0) begin errors++; $display("FAIL zero_bypass got %h want 0000", ReadA); end
    commit();
    RegWrite = 0; writeReg = 2; writeValue = 16'hABCD; srcA = 0; srcB = 2; #1;
    checks++;
    if (ReadA !== 16'h0) begin errors++; $display("FAIL zero_write got %h want 0000", ReadA); end
    commit();
    checks++;
    if (ReadB !== 16'h0002) begin errors++; $display("FAIL no_write_en got %h want 0002", ReadB); end
    idle();
  endtask

  task automatic test_bypass();
    RegWrite = 1; writeReg = 3; writeValue = 16'h1234; srcA = 3; srcB = 4; #1;
    checks++;
    if (ReadA !== 16'h1234 || ReadB !== 16'h0004) begin
      errors++; $display("FAIL bypass got A=%h B=%h want 1234 0004", ReadA, ReadB);
    end
    commit();
    // Back-to-back writes to r3: the last one wins.
    writeValue = 16'h4321; commit();
    idle(); #1;
    checks++;
    if (ReadA !== 16'h4321) begin errors++; $display("FAIL back_to_back got %h want 4321", ReadA); end
  endtask

  task automatic test_scoreboard();
    SetPend = 1; pendReg = 5; commit();
    idle(); srcB = 5; srcA = 1; #1;
    checks++;
    if (ValidB !== 1'b0 || PendAny !== 1'b1 || ValidA !== 1'b1) begin
      errors++; $display("FAIL pend_set got VB=%b PA=%b VA=%b want 0 1 1", ValidB, PendAny, ValidA);
    end
    RegWrite = 1; writeReg = 5; writeValue = 16'h0055; #1;
    checks++;
    if (ValidB !== 1'b1 || ReadB !== 16'h0055 || PendAny !== 1'b1) begin
      errors++; $display("FAIL pend_bypass got VB=%b B=%h PA=%b want 1 0055 1", ValidB, ReadB, PendAny);
    end
    commit();
    idle(); #1;
    checks++;
    if (PendAny !== 1'b0 || ValidB !== 1'b1) begin
      errors++; $display("FAIL pend_clear got PA=%b VB=%b want 0 1", PendAny, ValidB);
    end
    // SetPend on r0 is ignored and PendAny excludes same-cycle SetPend.
    SetPend = 1; pendReg = 0; #1;
    checks++;
    if (PendAny !== 1'b0) begin errors++; $display("FAIL pend_same_cycle got %b want 0", PendAny); end
    commit(); idle(); srcA = 0; #1;
    checks++;
    if (PendAny !== 1'b0 || ValidA !== 1'b1) begin
      errors++; $display("FAIL pend_zero got PA=%b VA=%b want 0 1", PendAny, ValidA);
    end
    // Set and clear on the same register: set wins.
    SetPend = 1; pendReg = 4; RegWrite = 1; writeReg = 4; writeValue = 16'h0444; commit();
    idle(); srcA = 4; #1;
    checks++;
    if (ValidA !== 1'b0 || ReadA !== 16'h0444) begin
      errors++; $display("FAIL set_wins got VA=%b A=%h want 0 0444", ValidA, ReadA);
    end
    // Set and clear on different registers both apply; re-set is idempotent.
    SetPend = 1; pendReg = 6; RegWrite = 1; writeReg = 4; writeValue = 16'h0400; commit();
    RegWrite = 0; commit();
    idle(); srcA = 6; srcB = 4; #1;
    checks++;
    if (ValidA !== 1'b0 || ValidB !== 1'b1 || ReadB !== 16'h0400) begin
      errors++; $display("FAIL set_clear_diff got VA=%b VB=%b B=%h want 0 1 0400", ValidA, ValidB, ReadB);
    end
    RegWrite = 1; writeReg = 6; writeValue = 16'h0006; commit();
    idle(); #1;
    checks++;
    if (ValidA !== 1'b1 || PendAny !== 1'b0) begin
      errors++; $display("FAIL reset_single_clear got VA=%b PA=%b want 1 0", ValidA, PendAny);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RegWrite   = ($urandom_range(0, 1) == 1);
      writeReg   = A'($urandom);
      writeValue = W'($urandom);
      SetPend    = ($urandom_range(0, 2) == 0);
      pendReg    = A'($urandom);
      srcA       = A'($urandom);
      srcB       = ($urandom_range(0, 3) == 0) ? writeReg : A'($urandom);
      #1;
      checks++;
      if (ReadA !== exp_read(srcA) || ReadB !== exp_read(srcB)) begin
        errors++; $display("FAIL rand_read n=%0d got A=%h B=%h want %h %h", n, ReadA, ReadB, exp_read(srcA), exp_read(srcB));
      end
      checks++;
      if (ValidA !== exp_valid(srcA) || ValidB !== exp_valid(srcB) || PendAny !== exp_any()) begin
        errors++; $display("FAIL rand_valid n=%0d got VA=%b VB=%b PA=%b want %b %b %b", n, ValidA, ValidB, PendAny, exp_valid(srcA), exp_valid(srcB), exp_any());
      end
      commit();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    RegWrite = 1; writeReg = 2; writeValue = 16'h0002; commit();
    idle(); SetPend = 1; pendReg = 2; commit();
    idle(); srcA = 2; #1;
    checks++;
    if (ValidA !== 1'b0 || ReadA !== 16'h0002) begin
      errors++; $display("FAIL mid_setup got VA=%b A=%h want 0 0002", ValidA, ReadA);
    end
    RST_N = 0; model_clear(); #1;
    checks++;
    if (ReadA !== 16'h0 || ValidA !== 1'b1 || PendAny !== 1'b0) begin
      errors++; $display("FAIL mid_reset got A=%h VA=%b PA=%b want 0000 1 0", ReadA, ValidA, PendAny);
    end
    commit();
    RST_N = 1; #1;
    checks++;
    if (ReadA !== 16'h0 || ValidA !== 1'b1) begin
      errors++; $display("FAIL post_reset got A=%h VA=%b want 0000 1", ReadA, ValidA);
    end
    commit();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
